scan_sel_gen: RTL
=================

# scan_sel_gen

Time-multiplexing scan controller that sits directly upstream of the team's 2-to-4 binary decoder. It steps a 2-bit digit index through four display positions at a programmable dwell rate and drives the decoder's `binary_in` and `en` inputs. It also presents the 4-bit data nibble for the active position to the segment path. An optional dead-time interval blanks the enable between positions to suppress ghosting.

## Interface
- `DWELL_CYCLES`, default 50000: clock cycles each position is active; must be ≥1.
- `DEAD_CYCLES`, default 8: blanking cycles between positions; must be ≥1; used only with the dead-time macro.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: reset. One clock; reset is synchronous and active-low.
- `run`, input, 1: scan enable; low forces idle.
- `digit_mask`, input, 4: bit i = 1 enables position i.
- `data_in`, input, 16: nibble i = `data_in[4i+3:4i]`.
- `sel`, output, 2: position index; drives the decoder's `binary_in`.
- `en`, output, 1: drives the decoder's `en`.
- `data_out`, output, 4: nibble of the current `sel`.
- `frame_done`, output, 1: one-cycle pulse when `sel` wraps from 3 to 0.

## Operation
- States:
  - S_IDLE: `en`=0, `sel`=0, counter=0.
  - S_ACTIVE: `en`=`digit_mask[sel]`.
  - S_DEAD: `en`=0, `sel` held.
- Transitions:
  - S_IDLE → S_ACTIVE when `run`=1. `sel`=0 and the counter is cleared.
  - S_ACTIVE: the counter counts 0..DWELL_CYCLES-1. On the terminal count, go to S_DEAD and clear the counter.
  - S_DEAD: the counter counts 0..DEAD_CYCLES-1. On the terminal count, `sel`←`sel`+1 (modulo 4, 3 wraps to 0), go to S_ACTIVE, and clear the counter.
  - `run`=0 in any state → S_IDLE on the next edge: `sel`=0, `en`=0, counter cleared, no `frame_done`.
- `frame_done` is asserted in the cycle after the `sel` 3→0 advance. It is never asserted on entry from S_IDLE.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `data_out` is registered from the nibble of the next-state `sel`.
- Masked positions are still visited for the full dwell with `en`=0. The scan period is independent of the mask.
- Counter width is `$clog2(max(DWELL_CYCLES, DEAD_CYCLES))` with a minimum of 1 bit. Counting is unsigned with no overflow beyond the terminal count.

## Timing
- Reset values: `sel`=0, `en`=0, `data_out`=0, `frame_done`=0, state S_IDLE, counter 0.
- `run` rising: on the next edge the state is S_ACTIVE, `sel`=0, and `en`=`digit_mask[0]` is visible.
- Position period is DWELL_CYCLES+DEAD_CYCLES cycles, with `en` high for at most DWELL_CYCLES of them. Frame period is 4× the position period.
- Changes on `digit_mask` or `data_in` appear on `en`/`data_out` one cycle later, including mid-dwell.
- `run`=0 together with a terminal count: idle takes priority and `sel` does not advance.
- `rst_n`=0 mid-frame: all outputs return to reset values on that edge.

## Configuration
- `SCAN_DEADTIME_EN` defined: S_DEAD exists as described.
- `SCAN_DEADTIME_EN` undefined:
  - S_DEAD is not compiled and `DEAD_CYCLES` is ignored.
  - On the S_ACTIVE terminal count, `sel` advances and the block stays in S_ACTIVE.
  - Position period is DWELL_CYCLES cycles.

## Structure
- Package `scan_pkg` holds:
  - `scan_state_t` enum {S_IDLE, S_ACTIVE, S_DEAD}, with S_DEAD under the macro;
  - `NUM_DIGITS`=4;
  - `SEL_W`=2.
- Sub-module `tick_counter`: parameterized mod-N counter with clear, enable, and a terminal-count output. It is instanced once, with N switched by state.

## Test plan
All scenarios use DWELL_CYCLES=4 and DEAD_CYCLES=2.
1. Reset: `rst_n`=0 for 3 cycles with `run`=1 → `sel`=0, `en`=0, `data_out`=0, `frame_done`=0. First edge after release → `sel`=0, `en`=1.
2. Full scan, `digit_mask`=4'hF, `data_in`=16'h4321, macro on → per position `en`=1 for 4 cycles then 0 for 2 cycles. `data_out` is 1,2,3,4 for `sel` 0..3. `frame_done` pulses once every 24 cycles.
3. `digit_mask`=4'b0101 → `en` is high only while `sel`=0 or 2. `sel` still visits 1 and 3, and the frame stays 24 cycles.
4. `run` dropped during S_DEAD with `sel`=2 → next cycle `sel`=0, `en`=0, no `frame_done`. `run` reasserted → full 4-cycle dwell at `sel`=0.
5. Macro off → `sel` advances every 4 cycles, `en` never drops between enabled positions, and `frame_done` comes every 16 cycles.
6. `digit_mask` bit 1 cleared in the 2nd dwell cycle of `sel`=1 → `en` falls in the following cycle while `sel` stays 1.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and constants for the digit scan controller.
// The S_DEAD state only exists when SCAN_DEADTIME_EN is defined.
package scan_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SEL_W      = 2;

`ifdef SCAN_DEADTIME_EN
    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DEAD
    } scan_state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE
    } scan_state_t;
`endif

endpackage

// File: rtl/scan_sel_gen_tick_counter.sv
// Mod-N tick counter: counts 0..last while enabled, then wraps to 0.
// tc flags the enabled cycle in which the count sits on its terminal value.
module tick_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic         tc
);

    logic [W-1:0] count;

    assign tc = en && (count == last);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == last) ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/scan_sel_gen.sv
// Scan controller feeding the 2-to-4 digit decoder: steps sel through four
// positions at a programmable dwell; blanking between positions needs SCAN_DEADTIME_EN.
//
// state    | meaning
// S_IDLE   | run low: sel=0, en=0, counter held clear
// S_ACTIVE | dwelling on sel, en follows digit_mask[sel]
// S_DEAD   | blanking gap before advancing sel (SCAN_DEADTIME_EN only)
module scan_sel_gen
    import scan_pkg::*;
#(
    parameter int DWELL_CYCLES = 50000,
    parameter int DEAD_CYCLES  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [3:0]       digit_mask,
    input  logic [15:0]      data_in,
    output logic [SEL_W-1:0] sel,
    output logic             en,
    output logic [3:0]       data_out,
    output logic             frame_done
);

    localparam int CNT_MAX = (DWELL_CYCLES > DEAD_CYCLES) ? DWELL_CYCLES : DEAD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    scan_state_t      state, state_n;
    logic [SEL_W-1:0] sel_n;
    logic             cnt_clr, cnt_en, cnt_tc, wrap;
    logic [CNT_W-1:0] cnt_last;

`ifdef SCAN_DEADTIME_EN
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
    assign cnt_last = (state == S_DEAD) ? DEAD_LAST : DWELL_LAST;
`else
    assign cnt_last = DWELL_LAST;
`endif

    tick_counter #(.W(CNT_W)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .last  (cnt_last),
        .tc    (cnt_tc)
    );

    // Dropping run wins over any terminal count, so sel never advances on the way out.
    always_comb begin
        state_n = state;
        sel_n   = sel;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        wrap    = 1'b0;
        if (!run) begin
            state_n = S_IDLE;
            sel_n   = '0;
            cnt_clr = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    state_n = S_ACTIVE;
                    sel_n   = '0;
                    cnt_clr = 1'b1;
                end
                S_ACTIVE: begin
                    cnt_en = 1'b1;
                    if (cnt_tc) begin
`ifdef SCAN_DEADTIME_EN
                        state_n = S_DEAD;
`else
                        sel_n = sel + SEL_W'(1);
                        wrap  = (sel == SEL_W'(NUM_DIGITS - 1));
`endif
                    end
                end
`ifdef SCAN_DEADTIME_EN
                S_DEAD: begin
                    cnt_en = 1'b1;
                    if (cnt_tc) begin
                        state_n = S_ACTIVE;
                        sel_n   = sel + SEL_W'(1);
                        wrap    = (sel == SEL_W'(NUM_DIGITS - 1));
                    end
                end
`endif
                default: begin
                    state_n = S_IDLE;
                    sel_n   = '0;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    // Outputs are registered from next-state values so they line up with state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            sel        <= '0;
            en         <= 1'b0;
            data_out   <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            sel        <= sel_n;
            en         <= (state_n == S_ACTIVE) && digit_mask[sel_n];
            data_out   <= data_in[{sel_n, 2'b00} +: 4];
            frame_done <= wrap;
        end
    end

endmodule
